// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, fixed-latency memory access,
// one-cycle mfc pulse back to the winning requester.
module mem_arbiter #(
   parameter int unsigned MEMDELAY = 4,
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          rnotw0,
   input  logic          rnotw1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          mfc0,
   output logic          mfc1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          gnt,
   output logic          mem_strobe,
   output logic          mem_rnotw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            last_gnt, last_gnt_d;
   logic            win;
   logic            gnt_d, busy_d, strobe_d, mfc0_d, mfc1_d, rnotw_d;
   logic [AW-1:0]   addr_d;
   logic [DW-1:0]   wdata_d, rdata_d;

   // Next-state and next-output logic; every output register is fed from here.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      last_gnt_d = last_gnt;
      win        = 1'b0;
      gnt_d      = gnt;
      strobe_d   = 1'b0;
      mfc0_d     = 1'b0;
      mfc1_d     = 1'b0;
      rnotw_d    = mem_rnotw;
      addr_d     = mem_addr;
      wdata_d    = mem_wdata;
      rdata_d    = rdata;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the requester that did not win last time goes first.
               win        = (req0 && req1) ? ~last_gnt : req1;
               state_d    = BUSY;
               gnt_d      = win;
               last_gnt_d = win;
               rnotw_d    = win ? rnotw1 : rnotw0;
               addr_d     = win ? addr1  : addr0;
               wdata_d    = win ? wdata1 : wdata0;
               strobe_d   = 1'b1;
               cnt_d      = CW'(MEMDELAY - 1);
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_d = DONE;
               if (gnt) mfc1_d = 1'b1;
               else     mfc0_d = 1'b1;
               if (mem_rnotw) rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_gnt   <= 1'b1;
         gnt        <= 1'b0;
         busy       <= 1'b0;
         mem_strobe <= 1'b0;
         mfc0       <= 1'b0;
         mfc1       <= 1'b0;
         mem_rnotw  <= 1'b1;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata      <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         last_gnt   <= last_gnt_d;
         gnt        <= gnt_d;
         busy       <= busy_d;
         mem_strobe <= strobe_d;
         mfc0       <= mfc0_d;
         mfc1       <= mfc1_d;
         mem_rnotw  <= rnotw_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         rdata      <= rdata_d;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEMDELAY, default 4: memory read/write latency in cycles, counted from the cycle mem_strobe is high; legal range 1..15.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter DW, default 16: data width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 req0 / req1  input  1  access request from thread 0 / thread 1.
REQ-007 rnotw0 / rnotw1  input  1  1 = read, 0 = write, for the matching requester.
REQ-008 addr0 / addr1  input  AW  access address.
REQ-009 wdata0 / wdata1  input  DW  write data.
REQ-010 mfc0 / mfc1  output  1  memory-function-complete; one-cycle pulse to the granted requester.
REQ-011 rdata  output  DW  read data; valid while mfc0 or mfc1 is high.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 gnt  output  1  id of the requester currently or last granted.
REQ-014 mem_strobe  output  1  one-cycle start pulse to memory.
REQ-015 mem_rnotw  output  1  direction to memory.
REQ-016 mem_addr  output  AW, mem_wdata  output  DW  address/data to memory.
REQ-017 mem_rdata  input  DW  memory read data, valid MEMDELAY cycles after mem_strobe.

Function
REQ-018 States IDLE, BUSY, DONE; all outputs registered.
REQ-019 IDLE: no req -> stay IDLE; any req -> BUSY on the same edge.
REQ-020 Arbitration on that edge: one req -> grant it; both req -> grant the id != last_gnt (round-robin).
REQ-021 On grant: gnt <= id, last_gnt <= id, latch rnotw/addr/wdata of the winner into mem_rnotw/mem_addr/mem_wdata, mem_strobe <= 1, cnt <= MEMDELAY-1.
REQ-022 mem_strobe is high for exactly one cycle per access.
REQ-023 mem_rnotw/mem_addr/mem_wdata are held constant from the grant edge until the next grant.
REQ-024 BUSY: cnt decrements by 1 each cycle; when cnt==0, go to DONE, raise mfc<gnt>; on a read, rdata <= mem_rdata.
REQ-025 Write: rdata keeps its previous value.
REQ-026 mfc therefore rises exactly MEMDELAY cycles after mem_strobe rose.
REQ-027 DONE: clear mfc and go to IDLE after one cycle.
REQ-028 Requests are not sampled in BUSY or DONE.
REQ-029 Throughput is one access per MEMDELAY+2 cycles.
REQ-030 Requester protocol: hold req until mfc is seen, then drop it the next cycle. req still high in IDLE after DONE is a new access.
REQ-031 Fairness: with both req held continuously, grants alternate 0,1,0,1...; no requester waits more than one access.
REQ-032 MEMDELAY=1: BUSY lasts one cycle; cnt is loaded with 0.
REQ-033 Changes on addrN/wdataN/rnotwN after grant have no effect on the current access.

Reset
REQ-034 Reset forces: state IDLE, cnt 0, mem_strobe 0, mfc0 0, mfc1 0, busy 0, mem_rnotw 1, mem_addr 0, mem_wdata 0, rdata 0, gnt 0.
REQ-035 Reset forces last_gnt 1, so thread 0 wins the first tie.
REQ-036 Reset during BUSY or DONE aborts the access; no mfc is issued for it.
REQ-037 After reset deasserts, the first possible grant is on the first rising clk edge.

Verification
REQ-038 Read, req0 alone: rnotw0=1, addr0=16'h0010, mem_rdata=16'hBEEF. Required: mem_strobe one cycle with mem_addr 16'h0010; mfc0 high exactly 4 cycles after strobe rose; rdata 16'hBEEF; mfc1 stays 0.
REQ-039 Write, req1 alone: rnotw1=0, addr1=16'h8000, wdata1=16'h1234. Required: mem_rnotw 0, mem_wdata 16'h1234; mfc1 pulses once; rdata unchanged.
REQ-040 Tie after reset, req0 and req1 raised the same cycle and held per protocol. Required: grant order 0 then 1; second strobe 6 cycles after the first.
REQ-041 Continuous contention for 6 accesses. Required: gnt sequence 0,1,0,1,0,1; busy drops for exactly one cycle between accesses.
REQ-042 Reset asserted 2 cycles after strobe. Required: all outputs go to their reset values immediately; no mfc; next req0 is served normally.
REQ-043 MEMDELAY=1 build, req0 read. Required: mfc0 one cycle after strobe.
